// File: rtl/leaf_fetch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// leaf_fetch_scheduler_pkg: shared constants, types and helpers for the leaf fetch scheduler.
// Revision: 1.0
// ============================================================================
package leaf_fetch_scheduler_pkg;

    localparam int LEAF_CNT        = 8;
    localparam int LINE_WIDTH      = 512;
    localparam int WORDS_PER_LINE  = 16;
    localparam int LEN_SEQ         = 2048;
    localparam int ADDR_WIDTH      = 32;
    localparam int BUF_DEPTH       = 16;
    localparam int MAX_OUTSTANDING = 8;
    localparam int LINES           = LEN_SEQ / WORDS_PER_LINE;

    localparam int LEAF_W   = $clog2(LEAF_CNT);
    localparam int CREDIT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W    = $clog2(LINES + 1);

    typedef logic [LEAF_W-1:0]   leaf_idx_t;
    typedef logic [CREDIT_W-1:0] credit_t;
    typedef logic [IDX_W-1:0]    line_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam credit_t   CREDIT_FULL = credit_t'(BUF_DEPTH);
    localparam credit_t   CREDIT_ONE  = credit_t'(1);
    localparam line_idx_t LINES_IDX   = line_idx_t'(LINES);
    localparam line_idx_t IDX_ONE     = line_idx_t'(1);

    // Returns {found, leaf}: first set bit of req at or after start, wrapping.
    function automatic logic [LEAF_W:0] rr_pick(input logic [LEAF_CNT-1:0] req,
                                                input leaf_idx_t           start);
        logic [LEAF_W:0] res;
        leaf_idx_t       cand;
        res = '0;
        for (int i = LEAF_CNT - 1; i >= 0; i--) begin
            cand = leaf_idx_t'((int'(start) + i) % LEAF_CNT);
            if (req[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    function automatic leaf_idx_t next_leaf(input leaf_idx_t l);
        return leaf_idx_t'((int'(l) + 1) % LEAF_CNT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_fetch_scheduler_tag_fifo.sv
`default_nettype none
// ============================================================================
// leaf_tag_fifo: synchronous FIFO of leaf tags for in-flight memory reads.
// Revision: 1.0
// ============================================================================
module leaf_tag_fifo
    import leaf_fetch_scheduler_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  leaf_idx_t push_tag,
    input  logic      pop,
    output leaf_idx_t pop_tag,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    leaf_idx_t        mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_tag = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_tag;
    end

endmodule
`default_nettype wire

// File: rtl/leaf_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// leaf_fetch_scheduler: credit-gated round-robin line fetch feeding per-leaf burst buffers.
// Optional macro LEAF_FETCH_PAD_EN: after a run, idle credits are filled with PAD_WORD lines.
// Revision: 1.0
// ============================================================================
module leaf_fetch_scheduler
    import leaf_fetch_scheduler_pkg::*;
`ifdef LEAF_FETCH_PAD_EN
#(
    parameter logic [31:0] PAD_WORD = 32'h0
)
`endif
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_req_ready,
    input  logic                  i_mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0] i_mem_rsp_data,
    output logic [LEAF_CNT-1:0]   o_buf_enq,
    output logic [LINE_WIDTH-1:0] o_buf_data,
    input  logic [LEAF_CNT-1:0]   i_buf_deq
);
    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    credit_t               credit   [LEAF_CNT];
    line_idx_t             line_idx [LEAF_CNT];
    leaf_idx_t             rr_ptr;
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    leaf_idx_t             req_leaf;
    logic [LEAF_CNT-1:0]   enq;
    logic [LINE_WIDTH-1:0] buf_data;
    logic                  tag_full;
    logic                  tag_empty;
    leaf_idx_t             tag_head;
    logic                  accept_start;
    logic                  handshake;
    logic                  rsp_take;
    logic                  grant;
    logic                  all_fetched;
    logic                  run_done;
    logic [LEAF_CNT-1:0]   elig;
    logic [LEAF_CNT-1:0]   take;
    logic [LEAF_W:0]       pick;
    leaf_idx_t             grant_leaf;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  pad_grant;
    leaf_idx_t             pad_leaf;

    assign accept_start = (state == IDLE) && i_start;
    assign handshake    = req_valid && i_mem_req_ready;
    assign rsp_take     = i_mem_rsp_valid && !tag_empty;

    always_comb begin
        elig        = '0;
        all_fetched = 1'b1;
        for (int k = 0; k < LEAF_CNT; k++) begin
            elig[k] = (credit[k] != '0) && (line_idx[k] < LINES_IDX) && !tag_full;
            if (line_idx[k] != LINES_IDX) all_fetched = 1'b0;
        end
    end

    // Arbitration only runs with no request in flight, so a held request never moves.
    assign pick       = rr_pick(elig, rr_ptr);
    assign grant_leaf = pick[LEAF_W-1:0];
    assign grant      = (state == RUN) && !req_valid && pick[LEAF_W];
    assign grant_addr = base
                      + (ADDR_WIDTH'(grant_leaf) * ADDR_WIDTH'(LEN_SEQ))
                      + (ADDR_WIDTH'(line_idx[grant_leaf]) * ADDR_WIDTH'(WORDS_PER_LINE));

    always_comb begin
        state_nxt = state;
        run_done  = 1'b0;
        case (state)
            IDLE:  if (i_start) state_nxt = RUN;
            RUN:   if (all_fetched) state_nxt = DRAIN;
            DRAIN: if (tag_empty) begin
                state_nxt = IDLE;
                run_done  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

`ifdef LEAF_FETCH_PAD_EN
    logic                pad_active;
    logic [LEAF_CNT-1:0] has_credit;
    logic [LEAF_W:0]     pad_pick;

    always_comb begin
        has_credit = '0;
        for (int k = 0; k < LEAF_CNT; k++) has_credit[k] = (credit[k] != '0);
    end

    assign pad_pick  = rr_pick(has_credit, rr_ptr);
    assign pad_leaf  = pad_pick[LEAF_W-1:0];
    assign pad_grant = pad_active && (state == IDLE) && !i_start && !rsp_take && pad_pick[LEAF_W];

    always_ff @(posedge i_clk) begin
        if (i_rst || accept_start) pad_active <= 1'b0;
        else if (run_done)         pad_active <= 1'b1;
    end
`else
    assign pad_grant = 1'b0;
    assign pad_leaf  = '0;
`endif

    always_comb begin
        take = '0;
        if (handshake) take[req_leaf] = 1'b1;
        if (pad_grant) take[pad_leaf] = 1'b1;
    end

    // A returned and a consumed credit in the same cycle cancel; returns saturate at full.
    always_ff @(posedge i_clk) begin
        if (i_rst || accept_start) begin
            for (int k = 0; k < LEAF_CNT; k++) begin
                credit[k]   <= CREDIT_FULL;
                line_idx[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LEAF_CNT; k++) begin
                if (i_buf_deq[k] && !take[k]) begin
                    if (credit[k] != CREDIT_FULL) credit[k] <= credit[k] + CREDIT_ONE;
                end else if (!i_buf_deq[k] && take[k]) begin
                    credit[k] <= credit[k] - CREDIT_ONE;
                end
                if (handshake && (req_leaf == leaf_idx_t'(k))) line_idx[k] <= line_idx[k] + IDX_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)             base <= '0;
        else if (accept_start) base <= i_base_addr;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_leaf  <= '0;
        end else if (grant) begin
            req_valid <= 1'b1;
            req_addr  <= grant_addr;
            req_leaf  <= grant_leaf;
        end else if (handshake) begin
            req_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)          rr_ptr <= '0;
        else if (grant)     rr_ptr <= next_leaf(grant_leaf);
        else if (pad_grant) rr_ptr <= next_leaf(pad_leaf);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            enq      <= '0;
            buf_data <= '0;
        end else if (rsp_take) begin
            enq      <= {{(LEAF_CNT-1){1'b0}}, 1'b1} << tag_head;
            buf_data <= i_mem_rsp_data;
`ifdef LEAF_FETCH_PAD_EN
        end else if (pad_grant) begin
            enq      <= {{(LEAF_CNT-1){1'b0}}, 1'b1} << pad_leaf;
            buf_data <= {WORDS_PER_LINE{PAD_WORD}};
`endif
        end else begin
            enq      <= '0;
        end
    end

    leaf_tag_fifo #(
        .DEPTH    (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (handshake),
        .push_tag (req_leaf),
        .pop      (i_mem_rsp_valid),
        .pop_tag  (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    assign o_busy          = (state != IDLE);
    assign o_done          = run_done;
    assign o_mem_req_valid = req_valid;
    assign o_mem_req_addr  = req_addr;
    assign o_buf_enq       = enq;
    assign o_buf_data      = buf_data;

endmodule
`default_nettype wire

// File: tb/tb_leaf_fetch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_leaf_fetch_scheduler: scoreboard bench with a 2-cycle in-order memory model and buffer consumer.
// Revision: 1.0
// ============================================================================
module tb_leaf_fetch_scheduler;
    import leaf_fetch_scheduler_pkg::*;

    typedef struct {
        logic [LEAF_CNT-1:0]   onehot;
        logic [LINE_WIDTH-1:0] data;
    } enq_t;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        int                    due;
    } pend_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic                  busy, done, req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  mem_ready = 1'b0;
    logic                  rsp_v_mem = 1'b0;
    logic                  rsp_v_stale = 1'b0;
    logic [LINE_WIDTH-1:0] rsp_d_mem = '0;
    logic [LINE_WIDTH-1:0] rsp_d_stale = '0;
    logic [LEAF_CNT-1:0]   buf_enq;
    logic [LINE_WIDTH-1:0] buf_data;
    logic [LEAF_CNT-1:0]   deq_auto = '0;
    logic [LEAF_CNT-1:0]   deq_man = '0;

    int checks = 0, fails = 0, cyc = 0;
    int hs_cnt = 0, enq_cnt = 0, done_cnt = 0;
    int deq_limit = 0;
    int deq_cnt [LEAF_CNT];
    logic mem_en = 1'b1;
    logic rsp_hold = 1'b0;
    logic [ADDR_WIDTH-1:0] cur_base = '0;

    logic [ADDR_WIDTH-1:0] exp_req [$];
    enq_t                  exp_enq [$];
    pend_t                 pend [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef LEAF_FETCH_PAD_EN
    leaf_fetch_scheduler #(.PAD_WORD(32'hFFFF_FFFF)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .o_busy          (busy),
        .o_done          (done),
        .o_mem_req_valid (req_valid),
        .o_mem_req_addr  (req_addr),
        .i_mem_req_ready (mem_ready),
        .i_mem_rsp_valid (rsp_v_mem | rsp_v_stale),
        .i_mem_rsp_data  (rsp_v_stale ? rsp_d_stale : rsp_d_mem),
        .o_buf_enq       (buf_enq),
        .o_buf_data      (buf_data),
        .i_buf_deq       (deq_auto | deq_man)
    );
`else
    leaf_fetch_scheduler dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .o_busy          (busy),
        .o_done          (done),
        .o_mem_req_valid (req_valid),
        .o_mem_req_addr  (req_addr),
        .i_mem_req_ready (mem_ready),
        .i_mem_rsp_valid (rsp_v_mem | rsp_v_stale),
        .i_mem_rsp_data  (rsp_v_stale ? rsp_d_stale : rsp_d_mem),
        .o_buf_enq       (buf_enq),
        .o_buf_data      (buf_data),
        .i_buf_deq       (deq_auto | deq_man)
    );
`endif

    function automatic logic [LINE_WIDTH-1:0] line_data(input logic [ADDR_WIDTH-1:0] a);
        logic [LINE_WIDTH-1:0] d;
        for (int w = 0; w < WORDS_PER_LINE; w++) d[w*32 +: 32] = (a + 32'(w)) ^ 32'hC0DE_0000;
        return d;
    endfunction

    function automatic int leaf_of(input logic [ADDR_WIDTH-1:0] a);
        return int'((a - cur_base) / 32'(LEN_SEQ));
    endfunction

    task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act, input logic [LINE_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        fails++;
        $display("FAIL %s: observed value %0d", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_model();
        exp_req.delete();
        exp_enq.delete();
        pend.delete();
        hs_cnt = 0; enq_cnt = 0; done_cnt = 0;
        for (int k = 0; k < LEAF_CNT; k++) deq_cnt[k] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; deq_man = '0; rsp_v_stale = 1'b0;
        clear_model();
        ticks(2);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic do_start(input logic [ADDR_WIDTH-1:0] b);
        base_addr = b; cur_base = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_rr(input logic [ADDR_WIDTH-1:0] b, input int n);
        for (int i = 0; i < n; i++)
            exp_req.push_back(b + 32'((i % LEAF_CNT) * LEN_SEQ) + 32'((i / LEAF_CNT) * WORDS_PER_LINE));
    endtask

    task automatic wait_hs(input int n, input int budget);
        int t;
        t = 0;
        while (hs_cnt < n && t < budget) begin tick(); t++; end
        if (hs_cnt < n) fail_now("wait_handshakes_timeout", hs_cnt);
    endtask

    task automatic wait_enq(input int n, input int budget);
        int t;
        t = 0;
        while (enq_cnt < n && t < budget) begin tick(); t++; end
        if (enq_cnt < n) fail_now("wait_enqueues_timeout", enq_cnt);
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done_cnt < 1 && t < budget) begin tick(); t++; end
        if (done_cnt < 1) fail_now("wait_done_timeout", done_cnt);
    endtask

    // Memory model: in-order responses two cycles after each accepted request.
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            rsp_v_mem = 1'b0;
            if (mem_en && !rsp_hold && pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                rsp_v_mem = 1'b1;
                rsp_d_mem = line_data(p.addr);
                exp_enq.push_back('{onehot: LEAF_CNT'(1) << leaf_of(p.addr), data: line_data(p.addr)});
            end
            if (!rst && mem_en && req_valid && mem_ready)
                pend.push_back('{addr: req_addr, due: cyc + 2});
        end
    end

    // Monitor: checks requests and enqueues against the expectation queues; consumer returns credits.
    initial begin
        logic [ADDR_WIDTH-1:0] ea;
        enq_t                  ee;
        forever begin
            @(negedge clk);
            deq_auto = '0;
            if (!rst) begin
                if (req_valid && mem_ready) begin
                    hs_cnt++;
                    if (exp_req.size() == 0) fail_now("unexpected_request", int'(req_addr));
                    else begin
                        ea = exp_req.pop_front();
                        chk("request_addr", req_addr, ea);
                    end
                end
                if (buf_enq != '0) begin
                    enq_cnt++;
                    if (exp_enq.size() == 0) fail_now("unexpected_enqueue", int'(buf_enq));
                    else begin
                        ee = exp_enq.pop_front();
                        chk("enqueue_leaf", buf_enq, ee.onehot);
                        chk("enqueue_data", buf_data, ee.data);
                    end
                    for (int k = 0; k < LEAF_CNT; k++)
                        if (buf_enq[k] && deq_cnt[k] < deq_limit) begin
                            deq_auto[k] = 1'b1;
                            deq_cnt[k]++;
                        end
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int pad_lines;
`ifdef LEAF_FETCH_PAD_EN
        pad_lines = 2;
`else
        pad_lines = 0;
`endif
        tick();
        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_req_valid", req_valid, 0);
        chk("reset_req_addr", req_addr, 0);
        chk("reset_buf_enq", buf_enq, 0);
        chk("reset_buf_data", buf_data, 0);

        // Full run; the consumer stops returning credit for each leaf's last 16 lines.
        mem_ready = 1'b1; deq_limit = LINES - BUF_DEPTH;
        push_rr(32'h0, LEAF_CNT * LINES);
        do_start(32'h0);
        chk("busy_after_start", busy, 1);
        wait_done(6000);
        ticks(4);
        chk("done_once", done_cnt, 1);
        chk("busy_after_done", busy, 0);
        chk("basic_requests", hs_cnt, LEAF_CNT * LINES);
        chk("basic_enqueues", enq_cnt, LEAF_CNT * LINES);
        for (int i = 0; i < pad_lines; i++)
            exp_enq.push_back('{onehot: LEAF_CNT'(1) << 5, data: {LINE_WIDTH{1'b1}}});
        deq_man = 8'h20; tick(); deq_man = '0; tick();
        deq_man = 8'h20; tick(); deq_man = '0;
        ticks(10);
        chk("post_done_enqueues", enq_cnt, LEAF_CNT * LINES + pad_lines);
        chk("post_done_requests", hs_cnt, LEAF_CNT * LINES);
        chk("post_done_pending", exp_enq.size(), 0);

        // Backpressure: request must hold while ready is low, then exactly one handshake.
        do_reset();
        mem_ready = 1'b0; deq_limit = 0;
        exp_req.push_back(32'h100);
        do_start(32'h100);
        for (int t = 0; t < 10 && !req_valid; t++) tick();
        for (int t = 0; t < 5; t++) begin
            chk("hold_valid", req_valid, 1);
            chk("hold_addr", req_addr, 32'h100);
            tick();
        end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        ticks(6);
        chk("backpressure_handshakes", hs_cnt, 1);
        chk("backpressure_enqueues", enq_cnt, 1);

        // Outstanding cap, then credit exhaustion with no consumer.
        do_reset();
        mem_ready = 1'b1; rsp_hold = 1'b1; deq_limit = 0;
        push_rr(32'h0, LEAF_CNT * BUF_DEPTH);
        do_start(32'h0);
        ticks(60);
        chk("outstanding_cap", hs_cnt, MAX_OUTSTANDING);
        chk("cap_no_request", req_valid, 0);
        rsp_hold = 1'b0;
        wait_enq(MAX_OUTSTANDING, 50);
        wait_hs(LEAF_CNT * BUF_DEPTH, 1000);
        ticks(40);
        chk("credit_block_requests", hs_cnt, LEAF_CNT * BUF_DEPTH);
        chk("credit_block_no_done", done_cnt, 0);
        chk("credit_block_busy", busy, 1);
        exp_req.push_back(32'(3 * LEN_SEQ + BUF_DEPTH * WORDS_PER_LINE));
        deq_man = 8'h08; tick(); deq_man = '0;
        wait_hs(LEAF_CNT * BUF_DEPTH + 1, 20);
        ticks(20);
        chk("one_credit_one_request", hs_cnt, LEAF_CNT * BUF_DEPTH + 1);

        // Reset mid-run; stale responses afterwards must be dropped.
        do_reset();
        mem_ready = 1'b1; deq_limit = LINES - BUF_DEPTH;
        push_rr(32'h0, LEAF_CNT * LINES);
        do_start(32'h0);
        wait_hs(40, 200);
        mem_en = 1'b0; mem_ready = 1'b0;
        ticks(3);
        do_reset();
        mem_en = 1'b1; deq_limit = 0;
        for (int i = 0; i < 3; i++) begin
            rsp_v_stale = 1'b1;
            rsp_d_stale = {16{32'hDEAD_0000 + 32'(i)}};
            tick();
        end
        rsp_v_stale = 1'b0;
        ticks(4);
        chk("stale_enqueues", enq_cnt, 0);
        chk("stale_busy", busy, 0);
        mem_ready = 1'b1;
        push_rr(32'h40, LEAF_CNT * BUF_DEPTH);
        do_start(32'h40);
        wait_hs(LEAF_CNT * BUF_DEPTH, 1000);
        ticks(30);
        chk("restart_requests", hs_cnt, LEAF_CNT * BUF_DEPTH);
        chk("restart_queue_empty", exp_req.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/leaf_fetch_scheduler.md
Name: leaf_fetch_scheduler

Overview:
- Sequences memory reads that refill the per-leaf 512-bit burst buffers feeding the merger tree's input FIFOs.
- Arbitrates round-robin among LEAF_CNT leaves, gated by per-leaf buffer credits, and issues one line request per grant.
- Steers in-order memory responses to the owning leaf buffer.
- Signals completion when every leaf's run has been fetched and all responses have drained.

Parameters:
- LEAF_CNT, 8, number of leaf buffers (2*L)
- LINE_WIDTH, 512, bits per memory line and buffer entry
- WORDS_PER_LINE, 16, 32-bit words per line
- LEN_SEQ, 2048, words per leaf run; multiple of WORDS_PER_LINE
- ADDR_WIDTH, 32, word-address width
- BUF_DEPTH, 16, lines per leaf buffer (initial credit)
- MAX_OUTSTANDING, 8, in-flight requests; power of two

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse that begins a run
- i_base_addr  in  ADDR_WIDTH  word address of leaf 0's run; sampled on accepted i_start
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle pulse at run completion
- o_mem_req_valid  out  1  line read request valid
- o_mem_req_addr  out  ADDR_WIDTH  word address of the requested line
- i_mem_req_ready  in  1  memory accepts the request
- i_mem_rsp_valid  in  1  response line valid; always accepted, returned in request order
- i_mem_rsp_data  in  LINE_WIDTH  response line
- o_buf_enq  out  LEAF_CNT  one-hot enqueue to a leaf buffer
- o_buf_data  out  LINE_WIDTH  line for o_buf_enq
- i_buf_deq  in  LEAF_CNT  per-leaf line-dequeue strobes (return credit)

Behaviour:
- Reset: all outputs 0; state IDLE; credits = BUF_DEPTH; line indices 0; RR pointer 0; tag FIFO empty.
- Line count: LINES = LEN_SEQ/WORDS_PER_LINE (128 at defaults).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on i_start. Latch base; reset credits and line indices.
  - i_start is ignored outside IDLE.
  - RUN -> DRAIN when every leaf has issued LINES requests.
  - DRAIN -> IDLE when the tag FIFO is empty; o_done pulses on that transition cycle.
- Eligible leaf: credit>0, line index < LINES, and tag FIFO not full.
- Round-robin: search starts at last grant +1, modulo LEAF_CNT.
- Request output:
  - Address = base + leaf*LEN_SEQ + idx*WORDS_PER_LINE, modulo 2^ADDR_WIDTH.
  - Request is registered.
  - While valid && !ready, valid, address and leaf are held stable; no re-arbitration.
  - On handshake: push the leaf tag, decrement that leaf's credit, increment its index. A new grant may issue the next cycle.
- Credit update: i_buf_deq[k] increments credit k.
  - Increment and decrement in the same cycle leave credit unchanged.
  - An increment at BUF_DEPTH saturates and is ignored.
- Response path:
  - On i_mem_rsp_valid, pop the tag.
  - Next cycle: o_buf_enq[tag]=1 and o_buf_data=rsp data (1-cycle latency).
  - A response with the tag FIFO empty is dropped.
- Reset mid-run clears all state. Later stale responses are dropped because the tag FIFO is empty.
- Timing: o_busy = (state != IDLE). Outstanding count never exceeds MAX_OUTSTANDING.

Optional Feature:
- Macro: LEAF_FETCH_PAD_EN.
- Defined:
  - Module adds parameter PAD_WORD (default 32'h0).
  - After o_done, while in IDLE, each cycle one leaf with credit>0 is chosen round-robin.
  - That leaf receives a line of WORDS_PER_LINE copies of PAD_WORD via o_buf_enq, consuming one credit.
  - No memory request is issued for pad lines.
  - Padding continues until i_start or i_rst.
- Not defined: IDLE issues no enqueues.

Decomposition:
- Shared package: LEAF_CNT, LINE_WIDTH, WORDS_PER_LINE, ADDR_WIDTH constants; leaf-index typedef (clog2 LEAF_CNT); credit typedef (clog2 BUF_DEPTH+1); state enum.
- Sub-module: leaf_tag_fifo.
  - Synchronous FIFO of leaf indices, depth MAX_OUTSTANDING.
  - Provides full/empty flags.

Test Plan:
- Basic run: start with base=0 and memory always ready with 2-cycle response latency.
  - Expect requests 0, 2048, 4096 … 14336, then 16, 2064 … (RR order).
  - Expect 1024 enqueues, each to the correct leaf with the correct data.
  - Expect o_done once, and o_busy low afterwards.
- Credit block: no i_buf_deq.
  - Each leaf gets exactly 16 requests; requests stop at 128 total and o_done stays low.
  - Deq leaf 3 once -> exactly one more request, address 3*2048+256.
- Backpressure: i_mem_req_ready low 5 cycles -> o_mem_req_addr stable all 5 cycles; one handshake only.
- Outstanding cap: responses withheld -> at most 8 requests issued.
  - Release responses -> in-order enqueues to tags 0..7.
- Reset mid-run after 40 requests, then 3 stale responses -> no o_buf_enq.
  - Credits return to 16; next start resumes at address base+0.
- Pad (LEAF_FETCH_PAD_EN, PAD_WORD=32'hFFFFFFFF):
  - After done, deq leaf 5 twice -> two all-ones enqueues to leaf 5, no memory requests.
  - Without the macro -> none.
